// File: rtl/solitaire_pkg.sv
// solitaire_pkg: shared types and constants for the greedy peg solitaire player.
// Rev 1.0
`default_nettype none

package solitaire_pkg;

    localparam int BOARD_WIDTH_DEF = 7;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
        dir_e       dir;
    } move_t;

    // LEFT from column 0 can never be legal, so this move is always a no-op.
    localparam move_t NOP_MOVE = '{x: 3'd0, y: 3'd0, dir: DIR_LEFT};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/solitaire_scan_ctr.sv
// solitaire_scan_ctr: (y,x,dir) nested wrap counter, dir innermost.
// Rev 1.0
`default_nettype none

module solitaire_scan_ctr
    import solitaire_pkg::*;
#(
    parameter int BOARD_WIDTH = BOARD_WIDTH_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  inc_i,
    output move_t cur_o,
    output move_t nxt_o,
    output logic  last_o
);

    localparam logic [2:0] C_MAX = 3'(BOARD_WIDTH - 1);

    move_t cur_q;
    move_t cur_d;

    always_comb begin
        cur_d = cur_q;
        if (clr_i) begin
            cur_d = NOP_MOVE;
        end else if (inc_i) begin
            if (cur_q.dir != DIR_DOWN) begin
                cur_d.dir = dir_e'(cur_q.dir + 2'd1);
            end else begin
                cur_d.dir = DIR_LEFT;
                if (cur_q.x != C_MAX) begin
                    cur_d.x = cur_q.x + 3'd1;
                end else begin
                    cur_d.x = 3'd0;
                    cur_d.y = (cur_q.y != C_MAX) ? cur_q.y + 3'd1 : 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q <= NOP_MOVE;
        end else begin
            cur_q <= cur_d;
        end
    end

    assign cur_o  = cur_q;
    assign nxt_o  = cur_d;
    assign last_o = (cur_q.y == C_MAX) && (cur_q.x == C_MAX) && (cur_q.dir == DIR_DOWN);

endmodule

`default_nettype wire

// File: rtl/solitaire_player.sv
// solitaire_player: greedy autonomous player probing board moves one candidate at a time.
// Rev 1.0
`default_nettype none

module solitaire_player
    import solitaire_pkg::*;
#(
    parameter int BOARD_WIDTH = BOARD_WIDTH_DEF,
    parameter int MAX_MOVES   = 31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] piece_count,
    input  logic       game_over,
    output logic [2:0] piece_x,
    output logic [2:0] piece_y,
    output logic [1:0] direction,
    output logic       busy,
    output logic       done,
    output logic       solved,
    output logic [4:0] moves_made,
    output logic       mv_strobe,
    output logic [2:0] mv_x,
    output logic [2:0] mv_y,
    output logic [1:0] mv_dir
);

    state_e     state_q, state_d;
    logic [5:0] cnt_q;
    logic [4:0] moves_q;
    move_t      probe_q;
    move_t      mv_q;
    logic       busy_q, done_q, mv_strobe_q;

    move_t w_cur, w_nxt;
    logic  w_last, w_clr, w_inc, w_accept, w_budget_hit;

    solitaire_scan_ctr #(.BOARD_WIDTH(BOARD_WIDTH)) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (w_clr),
        .inc_i  (w_inc),
        .cur_o  (w_cur),
        .nxt_o  (w_nxt),
        .last_o (w_last)
    );

    // A probe is accepted only if exactly one peg disappeared since the last look.
    assign w_accept     = (state_q == ST_CHECK) && (piece_count == cnt_q - 6'd1);
    assign w_budget_hit = (({1'b0, moves_q} + 6'd1) == 6'(MAX_MOVES));

    always_comb begin
        state_d = state_q;
        w_clr   = 1'b0;
        w_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PROBE;
                    w_clr   = 1'b1;
                end
            end
            ST_PROBE: state_d = ST_CHECK;
            ST_CHECK: begin
                if (w_accept) begin
                    w_clr   = 1'b1;
                    state_d = (w_budget_hit || game_over) ? ST_DONE : ST_PROBE;
                end else if (w_last || game_over) begin
                    state_d = ST_DONE;
                end else begin
                    w_inc   = 1'b1;
                    state_d = ST_PROBE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_PROBE;
                    w_clr   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            w_clr   = 1'b0;
            w_inc   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 6'd0;
            moves_q     <= 5'd0;
            probe_q     <= NOP_MOVE;
            mv_q        <= NOP_MOVE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mv_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            probe_q     <= (state_d == ST_PROBE) ? w_nxt : NOP_MOVE;
            busy_q      <= (state_d == ST_PROBE) || (state_d == ST_CHECK);
            done_q      <= (state_d == ST_DONE);
            mv_strobe_q <= 1'b0;
            if ((state_q == ST_IDLE) && (state_d == ST_PROBE)) begin
                moves_q <= 5'd0;
            end
            // Reload on every check so a board reset underneath re-baselines the count.
            if (((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_CHECK))
                && (state_d != ST_IDLE) && (state_d != ST_DONE || state_q == ST_CHECK)) begin
                cnt_q <= piece_count;
            end
            if (w_accept && (state_d != ST_IDLE)) begin
                mv_strobe_q <= 1'b1;
                mv_q        <= w_cur;
                moves_q     <= moves_q + 5'd1;
            end
        end
    end

    assign piece_x    = probe_q.x;
    assign piece_y    = probe_q.y;
    assign direction  = probe_q.dir;
    assign busy       = busy_q;
    assign done       = done_q;
    assign solved     = done_q && (piece_count == 6'd1);
    assign moves_made = moves_q;
    assign mv_strobe  = mv_strobe_q;
    assign mv_x       = mv_q.x;
    assign mv_y       = mv_q.y;
    assign mv_dir     = mv_q.dir;

endmodule

`default_nettype wire

// File: tb/tb_solitaire_player.sv
// tb_solitaire_player: directed bench driving two players against behavioural English boards.
// Rev 1.0
`default_nettype none

module tb_solitaire_player;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    function automatic bit cell_ok(input int x, input int y);
        return (x >= 0) && (x < 7) && (y >= 0) && (y < 7) && !(((x < 2) || (x > 4)) && ((y < 2) || (y > 4)));
    endfunction

    function automatic bit legal(input logic [48:0] b, input int x, input int y, input int d);
        int dx, dy;
        dx = (d == 0) ? -1 : (d == 1) ? 1 : 0;
        dy = (d == 2) ? -1 : (d == 3) ? 1 : 0;
        if (!cell_ok(x, y) || !cell_ok(x + dx, y + dy) || !cell_ok(x + 2 * dx, y + 2 * dy)) return 1'b0;
        return b[y * 7 + x] && b[(y + dy) * 7 + x + dx] && !b[(y + 2 * dy) * 7 + x + 2 * dx];
    endfunction

    function automatic logic [48:0] apply_mv(input logic [48:0] b, input int x, input int y, input int d);
        logic [48:0] r;
        int dx, dy;
        r  = b;
        dx = (d == 0) ? -1 : (d == 1) ? 1 : 0;
        dy = (d == 2) ? -1 : (d == 3) ? 1 : 0;
        r[y * 7 + x]                     = 1'b0;
        r[(y + dy) * 7 + x + dx]         = 1'b0;
        r[(y + 2 * dy) * 7 + x + 2 * dx] = 1'b1;
        return r;
    endfunction

    function automatic bit no_moves(input logic [48:0] b);
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++)
                for (int d = 0; d < 4; d++)
                    if (legal(b, x, y, d)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [48:0] full_board();
        logic [48:0] r;
        r = '0;
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < 7; x++)
                if (cell_ok(x, y) && !(x == 3 && y == 3)) r[y * 7 + x] = 1'b1;
        return r;
    endfunction

    // ---- DUT A (full budget) and its board ----
    logic        start_a, abort_a, brd_rst_a;
    logic [48:0] board_a;
    logic [5:0]  pc_a;
    logic        go_a;
    logic [2:0]  px_a, py_a, mvx_a, mvy_a;
    logic [1:0]  pd_a, mvd_a;
    logic        busy_a, done_a, solved_a, stb_a;
    logic [4:0]  moves_a;
    int          last_x, last_y, last_d;

    assign pc_a = 6'($countones(board_a));
    assign go_a = no_moves(board_a);

    always @(posedge clk) begin
        if (brd_rst_a) begin
            board_a <= full_board();
        end else if (legal(board_a, int'(px_a), int'(py_a), int'(pd_a))) begin
            board_a <= apply_mv(board_a, int'(px_a), int'(py_a), int'(pd_a));
            last_x  <= int'(px_a);
            last_y  <= int'(py_a);
            last_d  <= int'(pd_a);
        end
    end

    solitaire_player #(.BOARD_WIDTH(7), .MAX_MOVES(31)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .piece_count(pc_a), .game_over(go_a),
        .piece_x(px_a), .piece_y(py_a), .direction(pd_a),
        .busy(busy_a), .done(done_a), .solved(solved_a), .moves_made(moves_a),
        .mv_strobe(stb_a), .mv_x(mvx_a), .mv_y(mvy_a), .mv_dir(mvd_a)
    );

    // ---- DUT B (budget of 3 moves) and its board ----
    logic        start_b, abort_b, brd_rst_b;
    logic [48:0] board_b;
    logic [5:0]  pc_b;
    logic        go_b;
    logic [2:0]  px_b, py_b, mvx_b, mvy_b;
    logic [1:0]  pd_b, mvd_b;
    logic        busy_b, done_b, solved_b, stb_b;
    logic [4:0]  moves_b;

    assign pc_b = 6'($countones(board_b));
    assign go_b = no_moves(board_b);

    always @(posedge clk) begin
        if (brd_rst_b) board_b <= full_board();
        else if (legal(board_b, int'(px_b), int'(py_b), int'(pd_b)))
            board_b <= apply_mv(board_b, int'(px_b), int'(py_b), int'(pd_b));
    end

    solitaire_player #(.BOARD_WIDTH(7), .MAX_MOVES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .piece_count(pc_b), .game_over(go_b),
        .piece_x(px_b), .piece_y(py_b), .direction(pd_b),
        .busy(busy_b), .done(done_b), .solved(solved_b), .moves_made(moves_b),
        .mv_strobe(stb_b), .mv_x(mvx_b), .mv_y(mvy_b), .mv_dir(mvd_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int e, first_e, nstb, nop_bad, seq_bad, late_stb;
    int f_x, f_y, f_d, f_mv, f_pc;

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; brd_rst_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; brd_rst_b = 1'b1;
        last_x = 0; last_y = 0; last_d = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_moves", moves_a, 0);
        chk("rst_strobe", stb_a, 0);
        chk("rst_move_out", {px_a, py_a, pd_a}, 0);
        chk("rst_mv", {mvx_a, mvy_a, mvd_a}, 0);
        rst_n = 1'b1; brd_rst_a = 1'b0; brd_rst_b = 1'b0;
        step();
        chk("idle_nop", {px_a, py_a, pd_a}, 0);

        // ---- full greedy game on DUT A; start sampled at edge 0 ----
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        e = 0; first_e = -1; nstb = 0; nop_bad = 0; seq_bad = 0;
        f_x = 0; f_y = 0; f_d = 0; f_mv = 0; f_pc = 0;
        forever begin
            if (busy_a && (e % 2 == 1) && ({px_a, py_a, pd_a} != 8'd0)) nop_bad++;
            if (!busy_a && ({px_a, py_a, pd_a} != 8'd0)) nop_bad++;
            if (stb_a) begin
                nstb++;
                if (first_e < 0) begin
                    first_e = e; f_x = int'(mvx_a); f_y = int'(mvy_a); f_d = int'(mvd_a);
                    f_mv = int'(moves_a); f_pc = int'(pc_a);
                end
                if (int'(mvx_a) != last_x || int'(mvy_a) != last_y || int'(mvd_a) != last_d) seq_bad++;
            end
            if (done_a || e >= 30000) break;
            step();
            e++;
        end
        chk("game_done", done_a, 1);
        chk("first_strobe_edge", first_e, 88);
        chk("first_x", f_x, 3);
        chk("first_y", f_y, 1);
        chk("first_dir", f_d, 3);
        chk("first_moves", f_mv, 1);
        chk("first_pc", f_pc, 31);
        chk("check_cycle_nop", nop_bad, 0);
        chk("strobe_vs_board", seq_bad, 0);
        chk("moves_vs_pegs", moves_a, 32 - int'(pc_a));
        chk("strobe_count", nstb, moves_a);
        chk("solved_flag", solved_a, (pc_a == 6'd1));
        late_stb = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (stb_a) late_stb++;
        end
        chk("no_strobe_after_done", late_stb, 0);
        chk("done_nop", {px_a, py_a, pd_a}, 0);

        // ---- abort from DONE, then abort during PROBE of k=1 ----
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort_done_idle", {busy_a, done_a}, 0);
        brd_rst_a = 1'b1;
        step();
        brd_rst_a = 1'b0;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("restart_moves_clr", moves_a, 0);
        step();
        step();
        chk("probe_k1", {busy_a, px_a, py_a, pd_a}, {1'b1, 3'd0, 3'd0, 2'd1});
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("abort_probe_busy", busy_a, 0);
        chk("abort_probe_nop", {px_a, py_a, pd_a}, 0);
        chk("abort_probe_pc", pc_a, 32);
        step();
        chk("abort_stays_idle", {busy_a, done_a}, 0);

        // ---- async reset in a CHECK cycle, then rescan from k=0 ----
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        chk("in_check", busy_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_out", {px_a, py_a, pd_a, stb_a, moves_a}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("rescan_k0", {busy_a, px_a, py_a, pd_a}, {1'b1, 8'd0});
        step();
        step();
        chk("rescan_k1", {px_a, py_a, pd_a}, {3'd0, 3'd0, 2'd1});
        step();
        step();
        chk("rescan_k2", {px_a, py_a, pd_a}, {3'd0, 3'd0, 2'd2});
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;

        // ---- move budget of 3 on DUT B ----
        nstb = 0;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (stb_b) nstb++;
            if (done_b) break;
            step();
        end
        chk("b_done", done_b, 1);
        chk("b_strobes", nstb, 3);
        chk("b_moves", moves_b, 3);
        chk("b_pc", pc_b, 29);
        chk("b_solved", solved_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
